regfile_wport_arbiter: RTL and testbench
========================================

Name: regfile_wport_arbiter

Overview:
Arbitrates the single register-file write port between two writeback requesters: A (ALU/immediate results) and B (load/long-latency results). Each requester has a one-entry holding register and a valid/ready handshake. The block registers the winning write onto the port. It also drives the select of the 5-bit destination-address 2:1 mux (o = sel ? a : b), so sel=1 means A owns the port and sel=0 means B. Sits between the execute/memory stages and the register file.

Parameters:
AW, 5, register address width
DW, 32, write data width
CW, 8, width of saturating conflict counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
a_valid  in  1  requester A has a write
a_ready  out  1  A holding register can accept
a_addr  in  AW  A destination register
a_data  in  DW  A write data
b_valid  in  1  requester B has a write
b_ready  out  1  B holding register can accept
b_addr  in  AW  B destination register
b_data  in  DW  B write data
wr_en  out  1  register-file write enable (registered)
wr_addr  out  AW  register-file write address (registered)
wr_data  out  DW  register-file write data (registered)
sel  out  1  address-mux select; 1=A, 0=B (registered)
conflict_cnt  out  CW  saturating count of cycles where both holds are valid

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst); all state updates on the rising edge of clk.
- Reset values: both hold valids 0; wr_en 0; wr_addr 0; wr_data 0; sel 0; last_grant=A; a_older=0; conflict_cnt 0. Pending holds are discarded on reset mid-operation. Inputs are ignored in a cycle where rst=1.
- Hold registers hA/hB each store addr, data and a valid bit.
- x_ready = !hX_valid | grant_X (combinational; a hold drained this cycle can reload in the same cycle).
- Accept: x_valid & x_ready at an edge loads hX and sets its valid. The requester must hold valid/addr/data stable until accepted.
- Grant, combinational on hold state:
  - Neither valid: no grant.
  - One valid: grant it.
  - Both valid, same addr != 0: grant the older (a_older=1 -> A, else B).
  - Both valid otherwise: round-robin; grant the side != last_grant.
- On a grant edge:
  - The granted hold clears, unless it is reloaded the same edge.
  - last_grant <= granted side.
  - wr_addr <= hold addr; wr_data <= hold data; sel <= (grant==A).
  - wr_en <= (hold addr != 0). A write to $0 is retired silently and still consumes the slot.
- No grant: wr_en <= 0; wr_addr, wr_data and sel hold their previous values.
- Age tracking:
  - A loads while hB stays valid: a_older <= 0.
  - B loads while hA stays valid: a_older <= 1.
  - Both load the same edge: a_older <= 0 (B older).
  - Otherwise a_older is unchanged.
- Latency: accept at edge N, then wr_en at edge N+1 at the earliest. Throughput is one write per cycle. Sustained dual traffic alternates A,B,A,B.
- conflict_cnt increments at each edge where both holds are valid. It saturates at 2^CW-1 and does not wrap.
- Fairness: under continuous dual requests neither side waits more than one grant.

Test Plan:
- Reset, then idle 5 cycles -> wr_en=0, sel=0, a_ready=b_ready=1, conflict_cnt=0.
- A only: addr=5, data=0x1234 accepted at edge 1 -> at edge 2: wr_en=1, wr_addr=5, wr_data=0x1234, sel=1; at edge 3: wr_en=0.
- A and B asserted every cycle (A addr 3/data k; B addr 7/data 100+k) -> first grant B (last_grant reset=A), then strict alternation B,A,B,A. Ready deasserts only while the hold is full and not granted; conflict_cnt increments each cycle.
- Same-address collision: A and B both target addr 9; B loaded one cycle before A while hB blocked by a held A -> B written first, then A (final reg 9 = A data). Both loaded in the same cycle -> B first.
- Writes to $0 from A -> accepted, a_ready cycles normally, wr_en stays 0, sel updates to 1.
- Fill both holds, assert rst for one cycle -> next cycle: wr_en=0, holds empty, both ready=1, conflict_cnt=0. Force 300 dual-valid cycles -> conflict_cnt sticks at 255.

Source files
------------

// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter.
// Two requesters (A: ALU/immediate, B: load/long-latency) each feed a one-entry
// holding register through a valid/ready handshake. One hold per cycle wins the
// write port; the winning write is registered onto wr_en/wr_addr/wr_data/sel.
// Arbitration: a single valid hold wins; with both valid and the same non-zero
// destination the older entry wins (preserves write order to one register);
// otherwise round-robin against the last granted side.
module regfile_wport_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          sel,
  output logic [CW-1:0] conflict_cnt
);

  // Holding registers
  logic          ha_valid_r;
  logic [AW-1:0] ha_addr_r;
  logic [DW-1:0] ha_data_r;
  logic          hb_valid_r;
  logic [AW-1:0] hb_addr_r;
  logic [DW-1:0] hb_data_r;

  // Arbitration state: last_grant_a_r=1 means A was granted last;
  // a_older_r=1 means the A hold entry was loaded before the B hold entry.
  logic          last_grant_a_r;
  logic          a_older_r;

  logic          grant_a_s;
  logic          grant_b_s;
  logic          same_addr_s;
  logic          a_load_s;
  logic          b_load_s;

  // Same non-zero destination in both holds forces in-order retirement.
  assign same_addr_s = (ha_addr_r == hb_addr_r) && (ha_addr_r != {AW{1'b0}});

  // A hold that drains this cycle may be refilled on the same edge.
  assign a_ready  = !ha_valid_r || grant_a_s;
  assign b_ready  = !hb_valid_r || grant_b_s;
  assign a_load_s = a_valid && a_ready;
  assign b_load_s = b_valid && b_ready;

  // Grant selection from current hold state: age order on same-register
  // collisions, otherwise round-robin.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (ha_valid_r && hb_valid_r) begin
      if (same_addr_s) begin
        if (a_older_r) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end else if (last_grant_a_r) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b1;
      end
    end else if (ha_valid_r) begin
      grant_a_s = 1'b1;
    end else if (hb_valid_r) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Hold A: load on accept, clear when granted and not refilled.
  always_ff @(posedge clk) begin
    if (rst) begin
      ha_valid_r <= 1'b0;
      ha_addr_r  <= {AW{1'b0}};
      ha_data_r  <= {DW{1'b0}};
    end else if (a_load_s) begin
      ha_valid_r <= 1'b1;
      ha_addr_r  <= a_addr;
      ha_data_r  <= a_data;
    end else if (grant_a_s) begin
      ha_valid_r <= 1'b0;
    end
  end

  // Hold B: load on accept, clear when granted and not refilled.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_valid_r <= 1'b0;
      hb_addr_r  <= {AW{1'b0}};
      hb_data_r  <= {DW{1'b0}};
    end else if (b_load_s) begin
      hb_valid_r <= 1'b1;
      hb_addr_r  <= b_addr;
      hb_data_r  <= b_data;
    end else if (grant_b_s) begin
      hb_valid_r <= 1'b0;
    end
  end

  // Round-robin pointer follows the side that actually won the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_a_r <= 1'b1;
    end else if (grant_a_s) begin
      last_grant_a_r <= 1'b1;
    end else if (grant_b_s) begin
      last_grant_a_r <= 1'b0;
    end
  end

  // Age tracking: the side that loads while the other hold stays is younger;
  // simultaneous loads treat B as older.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_older_r <= 1'b0;
    end else if (a_load_s && b_load_s) begin
      a_older_r <= 1'b0;
    end else if (a_load_s && hb_valid_r && !grant_b_s) begin
      a_older_r <= 1'b0;
    end else if (b_load_s && ha_valid_r && !grant_a_s) begin
      a_older_r <= 1'b1;
    end
  end

  // Registered write port; writes to register 0 consume the slot silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= {AW{1'b0}};
      wr_data <= {DW{1'b0}};
      sel     <= 1'b0;
    end else if (grant_a_s) begin
      wr_en   <= (ha_addr_r != {AW{1'b0}});
      wr_addr <= ha_addr_r;
      wr_data <= ha_data_r;
      sel     <= 1'b1;
    end else if (grant_b_s) begin
      wr_en   <= (hb_addr_r != {AW{1'b0}});
      wr_addr <= hb_addr_r;
      wr_data <= hb_data_r;
      sel     <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Saturating count of cycles in which both holds compete for the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= {CW{1'b0}};
    end else if (ha_valid_r && hb_valid_r && (conflict_cnt != {CW{1'b1}})) begin
      conflict_cnt <= conflict_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: a timestamp-based behavioural
// model checked every cycle, directed scenarios with literal expectations, and
// a randomized phase with occasional resets.
module tb_regfile_wport_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          wr_en, sel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] conflict_cnt;

  regfile_wport_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sel(sel),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Holds carry a load timestamp; age = smaller timestamp, ties go to B.
  logic          live = 1'b0;
  logic          m_va = 1'b0, m_vb = 1'b0;
  logic [AW-1:0] m_aa = '0, m_ab = '0;
  logic [DW-1:0] m_da = '0, m_db = '0;
  int            m_ta = 0, m_tb = 0, cyc = 0;
  logic          m_last_a = 1'b1;
  logic          e_en = 1'b0, e_sel = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;
  int            e_cnt = 0;
  logic          acc_a = 1'b0, acc_b = 1'b0;
  logic [1:0]    m_g;
  logic          m_acc_a, m_acc_b;

  // Returns {grant A, grant B}.
  function automatic logic [1:0] pick(input logic va, input logic vb,
                                      input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                                      input int ta, input int tb, input logic last_a);
    if (va && vb) begin
      if (aa == ab && aa != 0) return (ta < tb) ? 2'b10 : 2'b01;
      return last_a ? 2'b01 : 2'b10;
    end
    return {va, vb};
  endfunction

  assign m_g     = pick(m_va, m_vb, m_aa, m_ab, m_ta, m_tb, m_last_a);
  assign m_acc_a = a_valid && (!m_va || m_g[1]);
  assign m_acc_b = b_valid && (!m_vb || m_g[0]);

  always @(posedge clk) begin
    if (rst) begin
      m_va <= 1'b0; m_vb <= 1'b0; m_last_a <= 1'b1;
      e_en <= 1'b0; e_addr <= '0; e_data <= '0; e_sel <= 1'b0; e_cnt <= 0;
      acc_a <= 1'b0; acc_b <= 1'b0; live <= 1'b1;
    end else begin
      acc_a <= m_acc_a;
      acc_b <= m_acc_b;
      if (m_va && m_vb && e_cnt < 255) e_cnt <= e_cnt + 1;
      if (m_g[1]) begin
        e_en <= (m_aa != 0); e_addr <= m_aa; e_data <= m_da; e_sel <= 1'b1; m_last_a <= 1'b1;
      end else if (m_g[0]) begin
        e_en <= (m_ab != 0); e_addr <= m_ab; e_data <= m_db; e_sel <= 1'b0; m_last_a <= 1'b0;
      end else begin
        e_en <= 1'b0;
      end
      if (m_acc_a) begin
        m_va <= 1'b1; m_aa <= a_addr; m_da <= a_data; m_ta <= cyc;
      end else if (m_g[1]) begin
        m_va <= 1'b0;
      end
      if (m_acc_b) begin
        m_vb <= 1'b1; m_ab <= b_addr; m_db <= b_data; m_tb <= cyc;
      end else if (m_g[0]) begin
        m_vb <= 1'b0;
      end
      cyc <= cyc + 1;
    end
  end

  // Log of retired writes as seen on the DUT port.
  typedef struct {logic s; logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  wr_t log_q[$];

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      check("a_ready", 32'(a_ready), 32'(!m_va || m_g[1]));
      check("b_ready", 32'(b_ready), 32'(!m_vb || m_g[0]));
      check("wr_en", 32'(wr_en), 32'(e_en));
      check("wr_addr", 32'(wr_addr), 32'(e_addr));
      check("wr_data", wr_data, e_data);
      check("sel", 32'(sel), 32'(e_sel));
      check("conflict_cnt", 32'(conflict_cnt), 32'(e_cnt));
      if (wr_en === 1'b1) log_q.push_back('{s: sel, addr: wr_addr, data: wr_data});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (acc_a) a_valid = 1'b0;
    if (acc_b) b_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((a_valid || b_valid) && n < 20) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(a_valid || b_valid), 32'd0);
    repeat (3) step();
  endtask

  task automatic dual(input int cycles);
    int ka = 0, kb = 0;
    repeat (cycles) begin
      if (!a_valid) begin a_valid = 1'b1; a_addr = 5'd3; a_data = 32'(ka); ka++; end
      if (!b_valid) begin b_valid = 1'b1; b_addr = 5'd7; b_data = 32'(100 + kb); kb++; end
      step();
    end
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    repeat (5) step();
    check("idle_wr_en", 32'(wr_en), 32'd0);
    check("idle_sel", 32'(sel), 32'd0);
    check("idle_a_ready", 32'(a_ready), 32'd1);
    check("idle_b_ready", 32'(b_ready), 32'd1);
    check("idle_cnt", 32'(conflict_cnt), 32'd0);

    // A only: write appears one edge after acceptance
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
    step();
    step();
    check("aonly_wr_en", 32'(wr_en), 32'd1);
    check("aonly_wr_addr", 32'(wr_addr), 32'd5);
    check("aonly_wr_data", wr_data, 32'h1234);
    check("aonly_sel", 32'(sel), 32'd1);
    step();
    check("aonly_wr_en_off", 32'(wr_en), 32'd0);

    // Sustained dual traffic: B first, then strict alternation
    log_q.delete();
    dual(12);
    drain();
    check("dual_sel0", 32'(log_q[0].s), 32'd0);
    check("dual_data0", log_q[0].data, 32'd100);
    check("dual_sel1", 32'(log_q[1].s), 32'd1);
    check("dual_data1", log_q[1].data, 32'd0);
    check("dual_sel2", 32'(log_q[2].s), 32'd0);
    check("dual_data2", log_q[2].data, 32'd101);
    check("dual_sel3", 32'(log_q[3].s), 32'd1);
    check("dual_data3", log_q[3].data, 32'd1);

    // Same-address collision where age overrides round-robin:
    // B is granted alone, refilled with addr 9 on the same edge A loads addr 9.
    log_q.delete();
    b_valid = 1'b1; b_addr = 5'd1; b_data = 32'hB1;
    step();
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hA9;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hB9;
    drain();
    check("coll_first_data", log_q[1].data, 32'hB9);
    check("coll_second_data", log_q[2].data, 32'hA9);
    check("coll_second_sel", 32'(log_q[2].s), 32'd1);

    // Both load addr 9 on the same edge: B first
    log_q.delete();
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hC9;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hD9;
    drain();
    check("same_edge_first", log_q[0].data, 32'hD9);
    check("same_edge_last", log_q[1].data, 32'hC9);

    // Write to register 0 from A: slot consumed, no enable, sel moves to A
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
    step();
    step();
    check("zero_pre_sel", 32'(sel), 32'd0);
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h55;
    step();
    check("zero_a_ready", 32'(a_ready), 32'd1);
    step();
    check("zero_wr_en", 32'(wr_en), 32'd0);
    check("zero_sel", 32'(sel), 32'd1);

    // Reset with both holds full discards them
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h2;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_b_ready", 32'(b_ready), 32'd1);
    check("rst_cnt", 32'(conflict_cnt), 32'd0);

    // Counter saturation
    dual(300);
    check("cnt_saturate", 32'(conflict_cnt), 32'd255);
    drain();

    // Randomized traffic with small address space and occasional reset
    repeat (3000) begin
      if (!a_valid && $urandom_range(0, 2) == 0) begin
        a_valid = 1'b1; a_addr = 5'($urandom_range(0, 3)); a_data = $urandom;
      end
      if (!b_valid && $urandom_range(0, 2) == 0) begin
        b_valid = 1'b1; b_addr = 5'($urandom_range(0, 3)); b_data = $urandom;
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
